// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipeline control path: opcodes, functs, ALU ops, memory ops,
// exception causes and the control bundles carried down the pipe.
package ctrl_pkg;

    localparam int ALUC_BITS = 4;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_COP0   = 6'b010000;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV  = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000, F_JALR = 6'b001001;
    localparam logic [5:0] F_SYSCALL = 6'b001100, F_BREAK = 6'b001101;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010, F_MTLO = 6'b010011;
    localparam logic [5:0] F_ERET = 6'b011000;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100, F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110, F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU  = 6'b101011;

    localparam logic [ALUC_BITS-1:0] ALUC_ADD = 4'd0,  ALUC_SUB  = 4'd1,  ALUC_AND = 4'd2;
    localparam logic [ALUC_BITS-1:0] ALUC_OR  = 4'd3,  ALUC_XOR  = 4'd4,  ALUC_NOR = 4'd5;
    localparam logic [ALUC_BITS-1:0] ALUC_SLT = 4'd6,  ALUC_SLTU = 4'd7,  ALUC_SLL = 4'd8;
    localparam logic [ALUC_BITS-1:0] ALUC_SRL = 4'd9,  ALUC_SRA  = 4'd10, ALUC_LUI = 4'd11;

    localparam logic [2:0] MEMOP_W  = 3'b000, MEMOP_H   = 3'b001, MEMOP_B  = 3'b010;
    localparam logic [2:0] MEMOP_LH = 3'b100, MEMOP_LHU = 3'b101;
    localparam logic [2:0] MEMOP_LB = 3'b110, MEMOP_LBU = 3'b111;

    localparam logic [1:0] EXT_SIGN = 2'b00, EXT_ZERO = 2'b01, EXT_LUI = 2'b10;

    localparam logic [4:0] EXC_SYS = 5'd8, EXC_BP = 5'd9, EXC_RI = 5'd10;

    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

    typedef struct packed {
        logic                 regwrite;
        logic                 regdst;
        logic                 alusrc;
        logic                 memtoreg;
        logic                 memwrite;
        logic                 hassign;
        logic [ALUC_BITS-1:0] alucontrol;
        logic [1:0]           hilo_en;
        logic [1:0]           hilo_mf;
        logic [2:0]           mem_op;
        logic                 div;
        logic                 eret;
    } ctrl_bundle_t;

    typedef struct packed {
        logic sys;
        logic bp;
        logic ri;
    } exc_t;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic [2:0] mem_op;
        logic       eret;
        exc_t       exc;
    } m_bundle_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } w_bundle_t;

    function automatic logic [4:0] exc_cause(input exc_t e);
        if (e.sys)     return EXC_SYS;
        else if (e.bp) return EXC_BP;
        else if (e.ri) return EXC_RI;
        else           return 5'd0;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Bus between the control unit (slave) and the decode/datapath/hazard/CP0 side (master).
interface pipeline_ctrl_unit_if #(
    parameter int ALUC_W  = 4,
    parameter int CAUSE_W = 5
);
    logic [5:0]         opD, functD;
    logic [4:0]         rtD;
    logic               equalD, stallE_i, flushE_i;
    logic               pcsrcD, branchD, jumpD;
    logic [1:0]         ext_typeD;
    logic               memtoregE, alusrcE, regdstE, regwriteE, hassignE;
    logic [ALUC_W-1:0]  alucontrolE;
    logic [1:0]         hilo_enE, hilo_mfE;
    logic               div_stall_o;
    logic               memtoregM, memwriteM, regwriteM;
    logic [2:0]         mem_opM;
    logic               memtoregW, regwriteW;
    logic               exception_o;
    logic [CAUSE_W-1:0] cause_o;
    logic               eret_o, flush_all_o;

    modport slave (
        input  opD, functD, rtD, equalD, stallE_i, flushE_i,
        output pcsrcD, branchD, jumpD, ext_typeD,
        output memtoregE, alusrcE, regdstE, regwriteE, hassignE, alucontrolE, hilo_enE, hilo_mfE,
        output div_stall_o, memtoregM, memwriteM, regwriteM, mem_opM, memtoregW, regwriteW,
        output exception_o, cause_o, eret_o, flush_all_o
    );

    modport master (
        output opD, functD, rtD, equalD, stallE_i, flushE_i,
        input  pcsrcD, branchD, jumpD, ext_typeD,
        input  memtoregE, alusrcE, regdstE, regwriteE, hassignE, alucontrolE, hilo_enE, hilo_mfE,
        input  div_stall_o, memtoregM, memwriteM, regwriteM, mem_opM, memtoregW, regwriteW,
        input  exception_o, cause_o, eret_o, flush_all_o
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational D-stage decode of op/funct/rt into the control bundle and exception flags.
// CTRL_ERET_EN: when defined, COP0 funct 011000 decodes as ERET instead of reserved.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   op_i,
    input  logic [5:0]   funct_i,
    input  logic [4:0]   rt_i,
    input  logic         equal_i,
    output ctrl_bundle_t ctrl_o,
    output exc_t         exc_o,
    output logic         branch_o,
    output logic         jump_o,
    output logic         pcsrc_o,
    output logic [1:0]   ext_type_o
);
    logic taken;

    always_comb begin
        ctrl_o     = '0;
        exc_o      = '0;
        branch_o   = 1'b0;
        jump_o     = 1'b0;
        taken      = 1'b0;
        ext_type_o = EXT_SIGN;
        case (op_i)
            OP_RTYPE: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdst   = 1'b1;
                case (funct_i)
                    F_ADD:  begin ctrl_o.alucontrol = ALUC_ADD; ctrl_o.hassign = 1'b1; end
                    F_ADDU: ctrl_o.alucontrol = ALUC_ADD;
                    F_SUB:  begin ctrl_o.alucontrol = ALUC_SUB; ctrl_o.hassign = 1'b1; end
                    F_SUBU: ctrl_o.alucontrol = ALUC_SUB;
                    F_AND:  ctrl_o.alucontrol = ALUC_AND;
                    F_OR:   ctrl_o.alucontrol = ALUC_OR;
                    F_XOR:  ctrl_o.alucontrol = ALUC_XOR;
                    F_NOR:  ctrl_o.alucontrol = ALUC_NOR;
                    F_SLT:  begin ctrl_o.alucontrol = ALUC_SLT; ctrl_o.hassign = 1'b1; end
                    F_SLTU: ctrl_o.alucontrol = ALUC_SLTU;
                    F_SLL, F_SLLV: ctrl_o.alucontrol = ALUC_SLL;
                    F_SRL, F_SRLV: ctrl_o.alucontrol = ALUC_SRL;
                    F_SRA, F_SRAV: ctrl_o.alucontrol = ALUC_SRA;
                    F_JR:   begin ctrl_o.regwrite = 1'b0; jump_o = 1'b1; end
                    F_JALR: jump_o = 1'b1;
                    F_MFHI: ctrl_o.hilo_mf = 2'b10;
                    F_MFLO: ctrl_o.hilo_mf = 2'b01;
                    F_MTHI: begin ctrl_o.regwrite = 1'b0; ctrl_o.hilo_en = 2'b10; end
                    F_MTLO: begin ctrl_o.regwrite = 1'b0; ctrl_o.hilo_en = 2'b01; end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        ctrl_o.regwrite = 1'b0;
                        ctrl_o.hilo_en  = 2'b11;
                        ctrl_o.hassign  = (funct_i == F_MULT) || (funct_i == F_DIV);
                        ctrl_o.div      = (funct_i == F_DIV) || (funct_i == F_DIVU);
                    end
                    F_SYSCALL: exc_o.sys = 1'b1;
                    F_BREAK:   exc_o.bp  = 1'b1;
                    default:   exc_o.ri  = 1'b1;
                endcase
            end
            // For REGIMM the datapath comparator reports rs<0 on equal_i; rt[0] selects BGEZ.
            OP_REGIMM: begin
                if (rt_i == 5'd0 || rt_i == 5'd1) begin
                    branch_o = 1'b1;
                    taken    = equal_i ^ rt_i[0];
                end else begin
                    exc_o.ri = 1'b1;
                end
            end
            OP_J:   jump_o = 1'b1;
            OP_JAL: begin jump_o = 1'b1; ctrl_o.regwrite = 1'b1; end
            OP_BEQ: begin branch_o = 1'b1; taken = equal_i;  end
            OP_BNE: begin branch_o = 1'b1; taken = ~equal_i; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
                case (op_i)
                    OP_ADDI:  begin ctrl_o.alucontrol = ALUC_ADD; ctrl_o.hassign = 1'b1; end
                    OP_SLTI:  begin ctrl_o.alucontrol = ALUC_SLT; ctrl_o.hassign = 1'b1; end
                    OP_SLTIU: ctrl_o.alucontrol = ALUC_SLTU;
                    OP_ANDI:  begin ctrl_o.alucontrol = ALUC_AND; ext_type_o = EXT_ZERO; end
                    OP_ORI:   begin ctrl_o.alucontrol = ALUC_OR;  ext_type_o = EXT_ZERO; end
                    OP_XORI:  begin ctrl_o.alucontrol = ALUC_XOR; ext_type_o = EXT_ZERO; end
                    OP_LUI:   begin ctrl_o.alucontrol = ALUC_LUI; ext_type_o = EXT_LUI;  end
                    default:  ctrl_o.alucontrol = ALUC_ADD;
                endcase
            end
            OP_COP0: begin
`ifdef CTRL_ERET_EN
                if (funct_i == F_ERET) ctrl_o.eret = 1'b1;
                else                   exc_o.ri    = 1'b1;
`else
                exc_o.ri = 1'b1;
`endif
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                case (op_i)
                    OP_LB:   ctrl_o.mem_op = MEMOP_LB;
                    OP_LBU:  ctrl_o.mem_op = MEMOP_LBU;
                    OP_LH:   ctrl_o.mem_op = MEMOP_LH;
                    OP_LHU:  ctrl_o.mem_op = MEMOP_LHU;
                    default: ctrl_o.mem_op = MEMOP_W;
                endcase
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                case (op_i)
                    OP_SB:   ctrl_o.mem_op = MEMOP_B;
                    OP_SH:   ctrl_o.mem_op = MEMOP_H;
                    default: ctrl_o.mem_op = MEMOP_W;
                endcase
            end
            default: exc_o.ri = 1'b1;
        endcase
        // A trapping instruction must not write anything or redirect fetch.
        if (|exc_o) begin
            ctrl_o     = '0;
            branch_o   = 1'b0;
            jump_o     = 1'b0;
            taken      = 1'b0;
            ext_type_o = EXT_SIGN;
        end
        pcsrc_o = branch_o & taken;
    end
endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline control unit: D decode, E/M/W control registers, divider interlock and M-stage
// exception resolution. CTRL_ERET_EN enables ERET decode and the eret_o output.
module pipeline_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ALUC_W     = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CAUSE_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_ctrl_unit_if.slave bus
);
    localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

    ctrl_bundle_t ctrlD, e_ctrl_q, e_ctrl_d;
    exc_t         excD, e_exc_q, e_exc_d;
    m_bundle_t    m_q, m_d;
    w_bundle_t    w_q, w_d;
    div_state_t   div_state_q;
    logic [5:0]   div_cnt_q;
    logic         exc_m, flush_all, div_stall, hold_e;

    ctrl_decode u_decode (
        .op_i       (bus.opD),
        .funct_i    (bus.functD),
        .rt_i       (bus.rtD),
        .equal_i    (bus.equalD),
        .ctrl_o     (ctrlD),
        .exc_o      (excD),
        .branch_o   (bus.branchD),
        .jump_o     (bus.jumpD),
        .pcsrc_o    (bus.pcsrcD),
        .ext_type_o (bus.ext_typeD)
    );

    assign exc_m     = |m_q.exc;
    assign flush_all = exc_m | m_q.eret;
    assign div_stall = ~flush_all &
                       (((div_state_q == DIV_IDLE) && e_ctrl_q.div) ||
                        ((div_state_q == DIV_BUSY) && (div_cnt_q != DIV_LAST)));
    assign hold_e    = bus.stallE_i | div_stall;

    always_comb begin
        e_ctrl_d = e_ctrl_q;
        e_exc_d  = e_exc_q;
        if (flush_all || bus.flushE_i) begin
            e_ctrl_d = '0;
            e_exc_d  = '0;
        end else if (!hold_e) begin
            e_ctrl_d = ctrlD;
            e_exc_d  = excD;
        end
    end

    // E -> M: a held E stage sends a bubble forward
    always_comb begin
        m_d = '0;
        if (!flush_all && !hold_e) begin
            m_d.memtoreg = e_ctrl_q.memtoreg;
            m_d.memwrite = e_ctrl_q.memwrite;
            m_d.regwrite = e_ctrl_q.regwrite;
            m_d.mem_op   = e_ctrl_q.mem_op;
            m_d.eret     = e_ctrl_q.eret;
            m_d.exc      = e_exc_q;
        end
    end

    // M -> W: the faulting instruction never commits its register write
    always_comb begin
        w_d.memtoreg = m_q.memtoreg;
        w_d.regwrite = m_q.regwrite & ~exc_m;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            e_ctrl_q <= '0;
            e_exc_q  <= '0;
            m_q      <= '0;
            w_q      <= '0;
        end else begin
            e_ctrl_q <= e_ctrl_d;
            e_exc_q  <= e_exc_d;
            m_q      <= m_d;
            w_q      <= w_d;
        end
    end

    // The IDLE cycle in which DIV is first seen counts as cycle 0, so BUSY starts at 1.
    always_ff @(posedge clk) begin
        if (!rst || flush_all || bus.flushE_i) begin
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= 6'd0;
        end else begin
            case (div_state_q)
                DIV_IDLE: begin
                    if (e_ctrl_q.div) begin
                        div_state_q <= DIV_BUSY;
                        div_cnt_q   <= 6'd1;
                    end
                end
                DIV_BUSY: begin
                    if (div_cnt_q == DIV_LAST) begin
                        if (!bus.stallE_i) begin
                            div_state_q <= DIV_IDLE;
                            div_cnt_q   <= 6'd0;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 6'd1;
                    end
                end
                default: begin
                    div_state_q <= DIV_IDLE;
                    div_cnt_q   <= 6'd0;
                end
            endcase
        end
    end

    assign bus.memtoregE   = e_ctrl_q.memtoreg;
    assign bus.alusrcE     = e_ctrl_q.alusrc;
    assign bus.regdstE     = e_ctrl_q.regdst;
    assign bus.regwriteE   = e_ctrl_q.regwrite;
    assign bus.hassignE    = e_ctrl_q.hassign;
    assign bus.alucontrolE = ALUC_W'(e_ctrl_q.alucontrol);
    assign bus.hilo_enE    = e_ctrl_q.hilo_en;
    assign bus.hilo_mfE    = e_ctrl_q.hilo_mf;
    assign bus.div_stall_o = div_stall;
    assign bus.memtoregM   = m_q.memtoreg;
    assign bus.memwriteM   = m_q.memwrite & ~exc_m;
    assign bus.regwriteM   = m_q.regwrite;
    assign bus.mem_opM     = m_q.mem_op;
    assign bus.memtoregW   = w_q.memtoreg;
    assign bus.regwriteW   = w_q.regwrite;
    assign bus.exception_o = exc_m;
    assign bus.cause_o     = CAUSE_W'(exc_cause(m_q.exc));
    assign bus.flush_all_o = flush_all;
`ifdef CTRL_ERET_EN
    assign bus.eret_o      = m_q.eret;
`else
    assign bus.eret_o      = 1'b0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit (DIV_CYCLES=4); ERET expectations follow CTRL_ERET_EN.
module tb_pipeline_ctrl_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_ctrl_unit_if #(.ALUC_W(4), .CAUSE_W(5)) bus ();
    pipeline_ctrl_unit #(.ALUC_W(4), .DIV_CYCLES(4), .CAUSE_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OPR     = 6'b000000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;

    // {op, rt, equalD, expected {pcsrcD, branchD, jumpD, ext_typeD}}
    localparam logic [16:0] DEC_TAB [8] = '{
        {6'b001000, 5'd0, 1'b0, 5'b00000},
        {6'b001101, 5'd0, 1'b0, 5'b00001},
        {6'b001111, 5'd0, 1'b0, 5'b00010},
        {6'b000100, 5'd0, 1'b1, 5'b11000},
        {6'b000101, 5'd0, 1'b1, 5'b01000},
        {6'b000001, 5'd1, 1'b0, 5'b11000},
        {6'b000001, 5'd0, 1'b0, 5'b01000},
        {6'b000010, 5'd0, 1'b0, 5'b00100}
    };

    // {op, funct, expected cause, expected eret}
`ifdef CTRL_ERET_EN
    localparam logic [17:0] EXC_TAB [4] = '{
        {6'b000000, 6'b001100, 5'd8,  1'b0},
        {6'b000000, 6'b001101, 5'd9,  1'b0},
        {6'b111111, 6'b000000, 5'd10, 1'b0},
        {6'b010000, 6'b011000, 5'd0,  1'b1}
    };
`else
    localparam logic [17:0] EXC_TAB [4] = '{
        {6'b000000, 6'b001100, 5'd8,  1'b0},
        {6'b000000, 6'b001101, 5'd9,  1'b0},
        {6'b111111, 6'b000000, 5'd10, 1'b0},
        {6'b010000, 6'b011000, 5'd10, 1'b0}
    };
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt, input logic eq);
        bus.opD    = op;
        bus.functD = fn;
        bus.rtD    = rt;
        bus.equalD = eq;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.stallE_i = 1'b0;
        bus.flushE_i = 1'b0;
        setd(OPR, FN_ADDU, 5'd0, 1'b0);
        tick();
        tick();
        n_tests++; if (bus.regwriteE !== 1'b0) begin n_fail++; $display("FAIL reset_regwriteE got %0b want 0", bus.regwriteE); end
        n_tests++; if (bus.regdstE !== 1'b0) begin n_fail++; $display("FAIL reset_regdstE got %0b want 0", bus.regdstE); end
        n_tests++; if (bus.regwriteM !== 1'b0) begin n_fail++; $display("FAIL reset_regwriteM got %0b want 0", bus.regwriteM); end
        n_tests++; if (bus.regwriteW !== 1'b0) begin n_fail++; $display("FAIL reset_regwriteW got %0b want 0", bus.regwriteW); end
        n_tests++; if (bus.cause_o !== 5'd0) begin n_fail++; $display("FAIL reset_cause got %0d want 0", bus.cause_o); end
        n_tests++; if ({bus.exception_o, bus.flush_all_o, bus.eret_o, bus.div_stall_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.exception_o, bus.flush_all_o, bus.eret_o, bus.div_stall_o}); end
        rst = 1'b1;
    endtask

    task automatic test_decode_d;
        logic [16:0] row;
        logic [4:0]  got;
        for (int i = 0; i < 8; i++) begin
            row = DEC_TAB[i];
            setd(row[16:11], 6'd0, row[10:6], row[5]);
            #1;
            got = {bus.pcsrcD, bus.branchD, bus.jumpD, bus.ext_typeD};
            n_tests++;
            if (got !== row[4:0]) begin
                n_fail++; $display("FAIL decode_row%0d op=%b got %b want %b", i, row[16:11], got, row[4:0]);
            end
        end
    endtask

    task automatic test_mem_ops;
        setd(6'b100000, 6'd0, 5'd0, 1'b0);   // LB
        tick();
        n_tests++; if ({bus.memtoregE, bus.alusrcE} !== 2'b11) begin n_fail++; $display("FAIL lb_E got %b want 11", {bus.memtoregE, bus.alusrcE}); end
        setd(6'b101001, 6'd0, 5'd0, 1'b0);   // SH
        tick();
        n_tests++; if (bus.mem_opM !== 3'b110) begin n_fail++; $display("FAIL lb_mem_opM got %b want 110", bus.mem_opM); end
        n_tests++; if ({bus.memtoregM, bus.memwriteM, bus.regwriteM} !== 3'b101) begin
            n_fail++; $display("FAIL lb_M_ctrl got %b want 101", {bus.memtoregM, bus.memwriteM, bus.regwriteM}); end
        setd(OPR, FN_ADDU, 5'd0, 1'b0);
        tick();
        n_tests++; if (bus.mem_opM !== 3'b001) begin n_fail++; $display("FAIL sh_mem_opM got %b want 001", bus.mem_opM); end
        n_tests++; if ({bus.memwriteM, bus.regwriteM} !== 2'b10) begin n_fail++; $display("FAIL sh_M_ctrl got %b want 10", {bus.memwriteM, bus.regwriteM}); end
        n_tests++; if ({bus.memtoregW, bus.regwriteW} !== 2'b11) begin n_fail++; $display("FAIL lb_W got %b want 11", {bus.memtoregW, bus.regwriteW}); end
        tick();
        n_tests++; if ({bus.memwriteM, bus.regwriteM, bus.mem_opM} !== 5'b01000) begin
            n_fail++; $display("FAIL addu_M got %b want 01000", {bus.memwriteM, bus.regwriteM, bus.mem_opM}); end
    endtask

    task automatic test_alu_e;
        setd(OPR, FN_SUB, 5'd0, 1'b0);
        tick();
        n_tests++; if (bus.alucontrolE !== 4'd1) begin n_fail++; $display("FAIL sub_alucontrolE got %0d want 1", bus.alucontrolE); end
        n_tests++; if ({bus.regdstE, bus.regwriteE, bus.hassignE, bus.alusrcE} !== 4'b1110) begin
            n_fail++; $display("FAIL sub_E_ctrl got %b want 1110", {bus.regdstE, bus.regwriteE, bus.hassignE, bus.alusrcE}); end
        setd(OPR, FN_MFHI, 5'd0, 1'b0);
        tick();
        n_tests++; if ({bus.hilo_mfE, bus.hilo_enE, bus.regwriteE} !== 5'b10001) begin
            n_fail++; $display("FAIL mfhi_E got %b want 10001", {bus.hilo_mfE, bus.hilo_enE, bus.regwriteE}); end
    endtask

    task automatic test_div;
        int stalls = 0;
        setd(OPR, FN_DIV, 5'd0, 1'b0);
        tick();
        setd(OPR, FN_ADDU, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (bus.div_stall_o === 1'b1) stalls++;
            if (i > 0) begin
                n_tests++; if (bus.regwriteM !== 1'b0) begin n_fail++; $display("FAIL div_bubble%0d regwriteM got %b want 0", i, bus.regwriteM); end
            end
            if (i == 3) begin
                n_tests++; if (bus.hilo_enE !== 2'b11) begin n_fail++; $display("FAIL div_in_E_last hilo_enE got %b want 11", bus.hilo_enE); end
            end
            tick();
        end
        n_tests++; if (stalls != 3) begin n_fail++; $display("FAIL div_stall_cycles got %0d want 3", stalls); end
        n_tests++; if ({bus.div_stall_o, bus.regwriteE, bus.hilo_enE, bus.regwriteM} !== 5'b01000) begin
            n_fail++; $display("FAIL div_leaves_E got %b want 01000", {bus.div_stall_o, bus.regwriteE, bus.hilo_enE, bus.regwriteM}); end
        tick();
        n_tests++; if (bus.regwriteM !== 1'b1) begin n_fail++; $display("FAIL div_next_in_M regwriteM got %b want 1", bus.regwriteM); end
    endtask

    task automatic test_exceptions;
        logic [17:0] row;
        for (int i = 0; i < 4; i++) begin
            row = EXC_TAB[i];
            setd(row[17:12], row[11:6], 5'd0, 1'b0);
            tick();
            n_tests++; if (bus.regwriteE !== 1'b0) begin n_fail++; $display("FAIL exc%0d_regwriteE got %b want 0", i, bus.regwriteE); end
            setd(OPR, FN_ADDU, 5'd0, 1'b0);
            tick();
            n_tests++; if (bus.cause_o !== row[5:1]) begin n_fail++; $display("FAIL exc%0d_cause got %0d want %0d", i, bus.cause_o, row[5:1]); end
            n_tests++; if ({bus.exception_o, bus.eret_o, bus.flush_all_o} !== {row[5:1] != 5'd0, row[0], 1'b1}) begin
                n_fail++; $display("FAIL exc%0d_flags got %b want %b", i, {bus.exception_o, bus.eret_o, bus.flush_all_o}, {row[5:1] != 5'd0, row[0], 1'b1}); end
            tick();
            n_tests++; if ({bus.flush_all_o, bus.exception_o, bus.regwriteE, bus.regwriteM, bus.regwriteW} !== 5'b00000) begin
                n_fail++; $display("FAIL exc%0d_after got %b want 00000", i, {bus.flush_all_o, bus.exception_o, bus.regwriteE, bus.regwriteM, bus.regwriteW}); end
        end
        tick();
        n_tests++; if (bus.regwriteE !== 1'b1) begin n_fail++; $display("FAIL exc_resume regwriteE got %b want 1", bus.regwriteE); end
    endtask

    task automatic test_stall_flush;
        setd(OPR, FN_SUBU, 5'd0, 1'b0);
        tick();
        bus.stallE_i = 1'b1;
        setd(6'b100000, 6'd0, 5'd0, 1'b0);
        tick();
        n_tests++; if ({bus.regdstE, bus.memtoregE, bus.alucontrolE} !== 6'b100001) begin
            n_fail++; $display("FAIL stall_holdE got %b want 100001", {bus.regdstE, bus.memtoregE, bus.alucontrolE}); end
        n_tests++; if (bus.regwriteM !== 1'b0) begin n_fail++; $display("FAIL stall_bubbleM regwriteM got %b want 0", bus.regwriteM); end
        bus.flushE_i = 1'b1;
        tick();
        n_tests++; if ({bus.regwriteE, bus.regdstE, bus.alucontrolE} !== 6'b000000) begin
            n_fail++; $display("FAIL stallflush_E got %b want 000000", {bus.regwriteE, bus.regdstE, bus.alucontrolE}); end
        bus.stallE_i = 1'b0;
        bus.flushE_i = 1'b0;
        tick();
        n_tests++; if (bus.memtoregE !== 1'b1) begin n_fail++; $display("FAIL release_lbE memtoregE got %b want 1", bus.memtoregE); end
    endtask

    task automatic test_div_reset;
        setd(OPR, FN_DIV, 5'd0, 1'b0);
        tick();
        setd(OPR, FN_ADDU, 5'd0, 1'b0);
        tick();
        n_tests++; if (bus.div_stall_o !== 1'b1) begin n_fail++; $display("FAIL divrst_busy got %b want 1", bus.div_stall_o); end
        rst = 1'b0;
        tick();
        n_tests++; if ({bus.div_stall_o, bus.hilo_enE, bus.regwriteE, bus.regwriteM, bus.regwriteW} !== 6'b000000) begin
            n_fail++; $display("FAIL divrst_outputs got %b want 000000", {bus.div_stall_o, bus.hilo_enE, bus.regwriteE, bus.regwriteM, bus.regwriteW}); end
        rst = 1'b1;
        tick();
        n_tests++; if ({bus.regwriteE, bus.div_stall_o} !== 2'b10) begin
            n_fail++; $display("FAIL divrst_resume got %b want 10", {bus.regwriteE, bus.div_stall_o}); end
        tick();
        n_tests++; if ({bus.regwriteM, bus.div_stall_o} !== 2'b10) begin
            n_fail++; $display("FAIL divrst_idle got %b want 10", {bus.regwriteM, bus.div_stall_o}); end
    endtask

    initial begin
        test_reset();
        test_decode_d();
        test_mem_ops();
        test_alu_e();
        test_div();
        test_exceptions();
        test_stall_flush();
        test_div_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
